mure_block_packer: RTL and testbench
====================================

Name: mure_block_packer

Overview:
- Parametrised successor to the multiple-retirement serializer; sits between the CPU commit interface and the trace encoder.
- Buffers NRET-wide commit groups in a FIFO and walks them one lane per cycle.
- Accumulates retired instructions into trace blocks and closes a block on any non-standard itype.
- Presents up to N closed blocks at once to the encoder over a valid/ready handshake, with input backpressure and overflow reporting.

Parameters:
- NRET, 2, commit lanes per cycle (>=1).
- N, 2, max blocks presented per output transfer (>=1).
- FIFO_DEPTH, 8, commit-group FIFO entries (power of 2, >=2).
- IRETIRE_LEN, mure_pkg::IRETIRE_LEN, iretire counter width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- valid_i  in  NRET  per-lane instruction valid.
- pc_i  in  NRET x XLEN  per-lane pc.
- itype_i  in  NRET x ITYPE_LEN  per-lane itype (0=std, 1=exc, 2=int, 3=eret, 4=nt-branch, 5=taken-branch, 6..7 jumps).
- compressed_i  in  NRET  per-lane 16-bit instruction.
- priv_i  in  PRIV_LEN  privilege level of the group.
- cause_i  in  CAUSE_LEN  trap cause of the group.
- tval_i  in  XLEN  trap value of the group.
- ready_o  out  1  FIFO can accept a group (= !full).
- overflow_o  out  1  one-cycle pulse: a group with a valid lane was dropped.
- valid_o  out  N  per-slot block valid, thermometer (slot 0 first).
- iretire_o  out  N x IRETIRE_LEN  halfwords retired in the block.
- ilastsize_o  out  N  last instruction size (1 = 32-bit).
- itype_o  out  N x ITYPE_LEN  closing itype.
- cause_o  out  N x CAUSE_LEN  cause; zero unless itype is 1 or 2.
- tval_o  out  N x XLEN  tval; zero unless itype is 1 or 2.
- priv_o  out  N x PRIV_LEN  privilege at block start.
- iaddr_o  out  N x XLEN  pc of the block's first instruction.
- ready_i  in  1  encoder accepts the whole presented set.

Behaviour:
- Reset values:
  - All outputs 0, except ready_o=1.
  - FIFO empty, lane pointer 0, no open block, slot count 0, state IDLE.
  - Reset mid-EMIT discards staged blocks.
- Push:
  - A group is pushed when OR(valid_i) && ready_o, storing all lane fields plus priv, cause and tval.
  - If OR(valid_i) && !ready_o, the group is dropped and overflow_o=1 on the next cycle.
  - An all-invalid group is never pushed.
  - Simultaneous push and pop on a full FIFO is not allowed; ready_o is registered from full.
- FSM states:
  - IDLE: leaves to SCAN when the FIFO is not empty; lane pointer 0.
  - SCAN:
    - Processes lane[ptr] each cycle; an invalid lane just advances ptr.
    - Std itype (0): if no block is open, open one with iaddr=pc and priv captured. Add 1 (compressed) or 2 to the iretire accumulator, saturating at all-ones. Record ilastsize=!compressed.
    - Itype 3..7: count the instruction as for std, then close the block into slot[count] with that itype; count++.
    - Itype 1/2: the trapping instruction is not counted. Close the block with cause/tval and iaddr=open iaddr, or this pc if none is open. iretire=0 if none is open; ilastsize keeps the accumulated value (0 if none). Remaining lanes of the group are discarded.
    - After the last processed lane: pop the FIFO, ptr=0.
    - Go to EMIT if count==N, or if the group is finished and count>0. Otherwise go to SCAN (FIFO not empty) or IDLE.
    - An open block persists across groups.
  - EMIT:
    - valid_o[i]=1 for i<count; slot fields are stable while waiting.
    - On ready_i: the next cycle clears valid_o and count=0, then resumes SCAN at the saved ptr (mid-group if the N limit hit), or goes to IDLE/SCAN by FIFO status.
    - Pushes continue during EMIT.
- Latency: a group pushed into an empty FIFO at cycle t starts processing at t+1. The first block is presented no earlier than t+1+lanes_processed.
- The iretire accumulator clears on every block close.

Test Plan:
- Std 32-bit at pc 0x100, then taken branch (itype 5) compressed at 0x104, in one group → one block: iretire=3, ilastsize=0, itype=5, iaddr=0x100, valid_o=2'b01.
- Two groups of two std 32-bit instructions (0x0, 0x4 / 0x8, 0xC), then a group with lane0 nt-branch at 0x10 → single block: iretire=10, iaddr=0x0, itype=4.
- Group lane0 eret (3) at 0x20, lane1 jump (6) at 0x24, N=2, ready_i low for 5 cycles → valid_o=2'b11 held with stable fields for 5 cycles; cleared one cycle after ready_i rises.
- Lane0 std at 0x40, lane1 exception (cause=2, tval=0xDEAD) → block: itype=1, iretire=2, iaddr=0x40, cause=2, tval=0xDEAD. Next group's lane0 exception with no open block → iretire=0, iaddr=its pc.
- Hold ready_i=0 and push FIFO_DEPTH+1 valid groups → ready_o=0 after 8 pushes; 9th group dropped with a 1-cycle overflow_o pulse; no corruption after drain.
- Assert rst_ni low during EMIT → all outputs 0 asynchronously, ready_o=1; a fresh group after release produces correct blocks.

Source files
------------

// File: rtl/mure_block_packer.sv
// rtl/mure_block_packer.sv - commit-group FIFO, lane walker and multi-block trace packer
package mure_pkg;
  localparam int XLEN        = 32;
  localparam int ITYPE_LEN   = 3;
  localparam int PRIV_LEN    = 2;
  localparam int CAUSE_LEN   = 5;
  localparam int IRETIRE_LEN = 8;
endpackage

module mure_block_packer #(
  parameter int NRET        = 2,
  parameter int N           = 2,
  parameter int FIFO_DEPTH  = 8,
  parameter int IRETIRE_LEN = mure_pkg::IRETIRE_LEN
) (
  input  logic                                          clk_i,
  input  logic                                          rst_ni,
  input  logic [NRET-1:0]                               valid_i,
  input  logic [NRET-1:0][mure_pkg::XLEN-1:0]           pc_i,
  input  logic [NRET-1:0][mure_pkg::ITYPE_LEN-1:0]      itype_i,
  input  logic [NRET-1:0]                               compressed_i,
  input  logic [mure_pkg::PRIV_LEN-1:0]                 priv_i,
  input  logic [mure_pkg::CAUSE_LEN-1:0]                cause_i,
  input  logic [mure_pkg::XLEN-1:0]                     tval_i,
  output logic                                          ready_o,
  output logic                                          overflow_o,
  output logic [N-1:0]                                  valid_o,
  output logic [N-1:0][IRETIRE_LEN-1:0]                 iretire_o,
  output logic [N-1:0]                                  ilastsize_o,
  output logic [N-1:0][mure_pkg::ITYPE_LEN-1:0]         itype_o,
  output logic [N-1:0][mure_pkg::CAUSE_LEN-1:0]         cause_o,
  output logic [N-1:0][mure_pkg::XLEN-1:0]              tval_o,
  output logic [N-1:0][mure_pkg::PRIV_LEN-1:0]          priv_o,
  output logic [N-1:0][mure_pkg::XLEN-1:0]              iaddr_o,
  input  logic                                          ready_i
);

  localparam int XLEN      = mure_pkg::XLEN;
  localparam int ITYPE_LEN = mure_pkg::ITYPE_LEN;
  localparam int PRIV_LEN  = mure_pkg::PRIV_LEN;
  localparam int CAUSE_LEN = mure_pkg::CAUSE_LEN;
  localparam int PW        = $clog2(FIFO_DEPTH);
  localparam int LW        = (NRET > 1) ? $clog2(NRET) : 1;
  localparam int CW        = $clog2(N + 1);
  localparam int SW        = (N > 1) ? $clog2(N) : 1;

  typedef struct packed {
    logic [NRET-1:0]                valid;
    logic [NRET-1:0][XLEN-1:0]      pc;
    logic [NRET-1:0][ITYPE_LEN-1:0] itype;
    logic [NRET-1:0]                compressed;
    logic [PRIV_LEN-1:0]            priv;
    logic [CAUSE_LEN-1:0]           cause;
    logic [XLEN-1:0]                tval;
  } grp_t;

  typedef enum logic [1:0] {IDLE, SCAN, EMIT} state_e;

  grp_t            mem_q [FIFO_DEPTH];
  logic [PW:0]     wr_ptr_q, rd_ptr_q, fifo_cnt, fifo_cnt_next;
  logic            fifo_empty, push, pop, ready_q, overflow_q;
  grp_t            head;

  state_e          state_q, state_d;
  logic [LW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SW-1:0]   slot;

  logic                   open_q, open_d;
  logic [XLEN-1:0]        oaddr_q, oaddr_d;
  logic [PRIV_LEN-1:0]    opriv_q, opriv_d;
  logic [IRETIRE_LEN-1:0] acc_q, acc_d;
  logic                   lsize_q, lsize_d;

  logic [N-1:0][IRETIRE_LEN-1:0] iretire_q, iretire_d;
  logic [N-1:0]                  ilastsize_q, ilastsize_d;
  logic [N-1:0][ITYPE_LEN-1:0]   itype_q, itype_d;
  logic [N-1:0][CAUSE_LEN-1:0]   cause_q, cause_d;
  logic [N-1:0][XLEN-1:0]        tval_q, tval_d;
  logic [N-1:0][PRIV_LEN-1:0]    priv_q, priv_d;
  logic [N-1:0][XLEN-1:0]        iaddr_q, iaddr_d;

  logic                   lane_v, lane_c, grp_done, close, trap;
  logic [ITYPE_LEN-1:0]   lane_it;
  logic [XLEN-1:0]        lane_pc, blk_addr;
  logic [PRIV_LEN-1:0]    blk_priv;
  logic [IRETIRE_LEN-1:0] blk_acc;
  logic                   blk_ls;

  function automatic logic [IRETIRE_LEN-1:0] sat_add(input logic [IRETIRE_LEN-1:0] a,
                                                      input logic                   inc2);
    logic [IRETIRE_LEN:0] s;
    s = {1'b0, a} + (inc2 ? (IRETIRE_LEN+1)'(2) : (IRETIRE_LEN+1)'(1));
    return s[IRETIRE_LEN] ? '1 : s[IRETIRE_LEN-1:0];
  endfunction

  // ---------------- commit-group FIFO ----------------
  assign fifo_cnt      = wr_ptr_q - rd_ptr_q;
  assign fifo_empty    = (fifo_cnt == '0);
  assign push          = (|valid_i) && ready_q;
  assign fifo_cnt_next = fifo_cnt + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
  assign head          = mem_q[rd_ptr_q[PW-1:0]];

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q[PW-1:0]] <= '{valid: valid_i, pc: pc_i, itype: itype_i,
                                   compressed: compressed_i, priv: priv_i,
                                   cause: cause_i, tval: tval_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ready_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      ready_q    <= (fifo_cnt_next != (PW+1)'(FIFO_DEPTH));
      overflow_q <= (|valid_i) && !ready_q;
    end
  end

  // ---------------- lane walker / block builder ----------------
  assign lane_v  = head.valid[ptr_q];
  assign lane_c  = head.compressed[ptr_q];
  assign lane_it = head.itype[ptr_q];
  assign lane_pc = head.pc[ptr_q];
  assign slot    = cnt_q[SW-1:0];

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    open_d      = open_q;
    oaddr_d     = oaddr_q;
    opriv_d     = opriv_q;
    acc_d       = acc_q;
    lsize_d     = lsize_q;
    iretire_d   = iretire_q;
    ilastsize_d = ilastsize_q;
    itype_d     = itype_q;
    cause_d     = cause_q;
    tval_d      = tval_q;
    priv_d      = priv_q;
    iaddr_d     = iaddr_q;
    pop         = 1'b0;
    grp_done    = 1'b0;
    close       = 1'b0;
    trap        = 1'b0;
    blk_acc     = '0;
    blk_ls      = 1'b0;
    blk_addr    = open_q ? oaddr_q : lane_pc;
    blk_priv    = open_q ? opriv_q : head.priv;

    case (state_q)
      IDLE: if (!fifo_empty) state_d = SCAN;

      SCAN: begin
        if (fifo_empty) begin
          state_d = IDLE;
        end else begin
          grp_done = (ptr_q == LW'(NRET - 1));
          if (lane_v) begin
            trap = (lane_it == ITYPE_LEN'(1)) || (lane_it == ITYPE_LEN'(2));
            if (trap) begin
              // The trapping instruction did not retire; lanes behind it are dead.
              close    = 1'b1;
              grp_done = 1'b1;
              blk_acc  = open_q ? acc_q : '0;
              blk_ls   = open_q ? lsize_q : 1'b0;
            end else begin
              blk_acc = sat_add(open_q ? acc_q : '0, !lane_c);
              blk_ls  = !lane_c;
              close   = (lane_it != '0);
              if (!close) begin
                open_d  = 1'b1;
                oaddr_d = blk_addr;
                opriv_d = blk_priv;
                acc_d   = blk_acc;
                lsize_d = blk_ls;
              end
            end
          end
          if (close) begin
            iretire_d[slot]   = blk_acc;
            ilastsize_d[slot] = blk_ls;
            itype_d[slot]     = lane_it;
            cause_d[slot]     = trap ? head.cause : '0;
            tval_d[slot]      = trap ? head.tval : '0;
            priv_d[slot]      = blk_priv;
            iaddr_d[slot]     = blk_addr;
            open_d            = 1'b0;
            acc_d             = '0;
            lsize_d           = 1'b0;
            cnt_d             = cnt_q + CW'(1);
          end
          if (grp_done) begin
            pop   = 1'b1;
            ptr_d = '0;
          end else begin
            ptr_d = ptr_q + LW'(1);
          end
          if (cnt_d == CW'(N) || (grp_done && cnt_d != '0)) begin
            state_d = EMIT;
          end else if (grp_done && fifo_cnt == (PW+1)'(1)) begin
            state_d = IDLE;
          end else begin
            state_d = SCAN;
          end
        end
      end

      EMIT: begin
        if (ready_i) begin
          cnt_d = '0;
          // A nonzero pointer means the slot limit cut a group short.
          state_d = (ptr_q == '0 && fifo_empty) ? IDLE : SCAN;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      open_q      <= 1'b0;
      oaddr_q     <= '0;
      opriv_q     <= '0;
      acc_q       <= '0;
      lsize_q     <= 1'b0;
      iretire_q   <= '0;
      ilastsize_q <= '0;
      itype_q     <= '0;
      cause_q     <= '0;
      tval_q      <= '0;
      priv_q      <= '0;
      iaddr_q     <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      open_q      <= open_d;
      oaddr_q     <= oaddr_d;
      opriv_q     <= opriv_d;
      acc_q       <= acc_d;
      lsize_q     <= lsize_d;
      iretire_q   <= iretire_d;
      ilastsize_q <= ilastsize_d;
      itype_q     <= itype_d;
      cause_q     <= cause_d;
      tval_q      <= tval_d;
      priv_q      <= priv_d;
      iaddr_q     <= iaddr_d;
    end
  end

  always_comb begin
    valid_o = '0;
    for (int i = 0; i < N; i++) begin
      valid_o[i] = (state_q == EMIT) && (CW'(i) < cnt_q);
    end
  end

  assign ready_o     = ready_q;
  assign overflow_o  = overflow_q;
  assign iretire_o   = iretire_q;
  assign ilastsize_o = ilastsize_q;
  assign itype_o     = itype_q;
  assign cause_o     = cause_q;
  assign tval_o      = tval_q;
  assign priv_o      = priv_q;
  assign iaddr_o     = iaddr_q;

endmodule

// File: tb/tb_mure_block_packer.sv
// tb/tb_mure_block_packer.sv - scoreboard bench for mure_block_packer
module tb_mure_block_packer;
  localparam int NRET = 2;
  localparam int N    = 2;
  localparam int XL   = mure_pkg::XLEN;
  localparam int IL   = mure_pkg::ITYPE_LEN;
  localparam int PL   = mure_pkg::PRIV_LEN;
  localparam int CL   = mure_pkg::CAUSE_LEN;
  localparam int RL   = mure_pkg::IRETIRE_LEN;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic [NRET-1:0]          valid_i = '0;
  logic [NRET-1:0][XL-1:0]  pc_i = '0;
  logic [NRET-1:0][IL-1:0]  itype_i = '0;
  logic [NRET-1:0]          compressed_i = '0;
  logic [PL-1:0]            priv_i = '0;
  logic [CL-1:0]            cause_i = '0;
  logic [XL-1:0]            tval_i = '0;
  logic                     ready_o, overflow_o, ready_i = 1'b1;
  logic [N-1:0]             valid_o, ilastsize_o;
  logic [N-1:0][RL-1:0]     iretire_o;
  logic [N-1:0][IL-1:0]     itype_o;
  logic [N-1:0][CL-1:0]     cause_o;
  logic [N-1:0][XL-1:0]     tval_o, iaddr_o;
  logic [N-1:0][PL-1:0]     priv_o;

  mure_block_packer #(.NRET(NRET), .N(N), .FIFO_DEPTH(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_i), .pc_i(pc_i), .itype_i(itype_i),
    .compressed_i(compressed_i), .priv_i(priv_i), .cause_i(cause_i), .tval_i(tval_i),
    .ready_o(ready_o), .overflow_o(overflow_o), .valid_o(valid_o), .iretire_o(iretire_o),
    .ilastsize_o(ilastsize_o), .itype_o(itype_o), .cause_o(cause_o), .tval_o(tval_o),
    .priv_o(priv_o), .iaddr_o(iaddr_o), .ready_i(ready_i));

  always #5 clk = ~clk;

  typedef struct {
    logic [RL-1:0] iretire;
    logic          ilastsize;
    logic [IL-1:0] itype;
    logic [CL-1:0] cause;
    logic [XL-1:0] tval;
    logic [PL-1:0] priv;
    logic [XL-1:0] iaddr;
  } blk_t;

  blk_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   ovf_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic expect_blk(input int ir, input logic ls, input int it, input int ca,
                            input logic [XL-1:0] tv, input int pr, input logic [XL-1:0] ia);
    blk_t e;
    e.iretire = RL'(ir); e.ilastsize = ls; e.itype = IL'(it); e.cause = CL'(ca);
    e.tval = tv; e.priv = PL'(pr); e.iaddr = ia;
    exp_q.push_back(e);
  endtask

  // Called at posedge+1; drives one group for one cycle.
  task automatic push(input logic [1:0] v, input logic [XL-1:0] pc0, input logic [XL-1:0] pc1,
                      input int it0, input int it1, input logic [1:0] c, input int pr,
                      input int ca, input logic [XL-1:0] tv, input bit wait_rdy);
    int t = 0;
    if (wait_rdy) begin
      while (!ready_o && t < 300) begin @(posedge clk); #1; t++; end
      if (t >= 300) chk("push_ready_timeout", 64'(ready_o), 64'd1);
    end
    valid_i = v; pc_i[0] = pc0; pc_i[1] = pc1;
    itype_i[0] = IL'(it0); itype_i[1] = IL'(it1); compressed_i = c;
    priv_i = PL'(pr); cause_i = CL'(ca); tval_i = tv;
    @(posedge clk); #1;
    valid_i = '0;
  endtask

  task automatic wait_valid(input logic [N-1:0] want, input string nm);
    int t = 0;
    while (valid_o !== want && t < 60) begin @(posedge clk); #1; t++; end
    chk(nm, 64'(valid_o), 64'(want));
  endtask

  task automatic wait_drain(input int limit, input string nm);
    int t = 0;
    while ((exp_q.size() != 0 || valid_o != '0) && t < limit) begin @(posedge clk); #1; t++; end
    repeat (3) @(posedge clk);
    #1;
    chk(nm, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin : monitor
    blk_t e;
    forever begin
      @(negedge clk);
      if (rst_n && overflow_o) ovf_cnt++;
      if (rst_n && |valid_o && ready_i) begin
        chk("valid_thermometer", 64'(valid_o & (valid_o + 1'b1)), 64'd0);
        for (int i = 0; i < N; i++) begin
          if (valid_o[i]) begin
            if (exp_q.size() == 0) begin
              chk("unexpected_block_iaddr", 64'(iaddr_o[i]), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
              e = exp_q.pop_front();
              chk("iretire",   64'(iretire_o[i]),   64'(e.iretire));
              chk("ilastsize", 64'(ilastsize_o[i]), 64'(e.ilastsize));
              chk("itype",     64'(itype_o[i]),     64'(e.itype));
              chk("cause",     64'(cause_o[i]),     64'(e.cause));
              chk("tval",      64'(tval_o[i]),      64'(e.tval));
              chk("priv",      64'(priv_o[i]),      64'(e.priv));
              chk("iaddr",     64'(iaddr_o[i]),     64'(e.iaddr));
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    #12;
    chk("rst_valid_o",    64'(valid_o),    64'd0);
    chk("rst_ready_o",    64'(ready_o),    64'd1);
    chk("rst_overflow_o", 64'(overflow_o), 64'd0);
    chk("rst_iretire_o",  64'(iretire_o),  64'd0);
    chk("rst_iaddr_o",    64'(iaddr_o),    64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // std 32-bit + compressed taken branch; cause/tval must be masked on non-trap close
    expect_blk(3, 1'b0, 5, 0, 0, 3, 32'h100);
    push(2'b11, 32'h100, 32'h104, 0, 5, 2'b10, 3, 7, 32'h55, 1'b1);
    wait_drain(60, "t1_drain");

    // block spans three groups; priv taken from the opening group
    expect_blk(10, 1'b1, 4, 0, 0, 1, 32'h0);
    push(2'b11, 32'h0, 32'h4, 0, 0, 2'b00, 1, 0, 0, 1'b1);
    push(2'b11, 32'h8, 32'hC, 0, 0, 2'b00, 1, 0, 0, 1'b1);
    push(2'b01, 32'h10, 32'h0, 4, 0, 2'b00, 2, 0, 0, 1'b1);
    wait_drain(80, "t2_drain");

    // exception after std; then interrupt with no open block (lane1 discarded)
    expect_blk(2, 1'b1, 1, 2, 32'hDEAD, 1, 32'h40);
    expect_blk(0, 1'b0, 2, 3, 32'hBEEF, 3, 32'h50);
    expect_blk(2, 1'b1, 5, 0, 0, 0, 32'h60);
    push(2'b11, 32'h40, 32'h44, 0, 1, 2'b00, 1, 2, 32'hDEAD, 1'b1);
    push(2'b11, 32'h50, 32'h54, 2, 0, 2'b00, 3, 3, 32'hBEEF, 1'b1);
    push(2'b01, 32'h60, 32'h0, 5, 0, 2'b00, 0, 0, 0, 1'b1);
    wait_drain(80, "t4_drain");

    // two blocks held under backpressure
    ready_i = 1'b0;
    expect_blk(2, 1'b1, 3, 0, 0, 0, 32'h20);
    expect_blk(2, 1'b1, 6, 0, 0, 0, 32'h24);
    push(2'b11, 32'h20, 32'h24, 3, 6, 2'b00, 0, 0, 0, 1'b1);
    wait_valid(2'b11, "t3_emit");
    for (int k = 0; k < 5; k++) begin
      chk("hold_valid",  64'(valid_o),    64'h3);
      chk("hold_iaddr0", 64'(iaddr_o[0]), 64'h20);
      chk("hold_iaddr1", 64'(iaddr_o[1]), 64'h24);
      chk("hold_itype1", 64'(itype_o[1]), 64'd6);
      @(posedge clk); #1;
    end
    ready_i = 1'b1;
    @(posedge clk); #1;
    chk("t3_cleared", 64'(valid_o), 64'd0);
    wait_drain(40, "t3_drain");

    // overflow: stall in EMIT, push FIFO_DEPTH+1 groups
    ready_i = 1'b0;
    expect_blk(2, 1'b1, 3, 0, 0, 0, 32'h200);
    expect_blk(2, 1'b1, 7, 0, 0, 0, 32'h204);
    push(2'b11, 32'h200, 32'h204, 3, 7, 2'b00, 0, 0, 0, 1'b1);
    wait_valid(2'b11, "ovf_emit");
    for (int k = 0; k < 9; k++) begin
      chk("ovf_ready_o", 64'(ready_o), (k < 8) ? 64'd1 : 64'd0);
      if (k < 8) expect_blk(2, 1'b1, 5, 0, 0, 1, 32'h300 + 32'(4 * k));
      push(2'b01, 32'h300 + 32'(4 * k), 32'h0, 5, 0, 2'b00, 1, 0, 0, 1'b0);
      chk("ovf_pulse", 64'(overflow_o), (k == 8) ? 64'd1 : 64'd0);
    end
    @(posedge clk); #1;
    chk("ovf_pulse_end", 64'(overflow_o), 64'd0);
    ready_i = 1'b1;
    wait_drain(200, "ovf_drain");

    // iretire saturation across 66 groups
    for (int k = 0; k < 66; k++) begin
      push(2'b11, 32'h1000 + 32'(8 * k), 32'h1004 + 32'(8 * k), 0, 0, 2'b00, 1, 0, 0, 1'b1);
    end
    expect_blk(255, 1'b1, 4, 0, 0, 1, 32'h1000);
    push(2'b01, 32'h2000, 32'h0, 4, 0, 2'b00, 2, 0, 0, 1'b1);
    wait_drain(800, "sat_drain");

    // asynchronous reset while blocks are staged
    ready_i = 1'b0;
    push(2'b11, 32'h80, 32'h84, 5, 5, 2'b00, 0, 0, 0, 1'b1);
    wait_valid(2'b11, "rst_emit");
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid_o",   64'(valid_o),   64'd0);
    chk("arst_ready_o",   64'(ready_o),   64'd1);
    chk("arst_iretire_o", 64'(iretire_o), 64'd0);
    chk("arst_itype_o",   64'(itype_o),   64'd0);
    chk("arst_iaddr_o",   64'(iaddr_o),   64'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    ready_i = 1'b1;
    expect_blk(2, 1'b0, 5, 0, 0, 2, 32'h90);
    push(2'b11, 32'h90, 32'h94, 0, 5, 2'b11, 2, 0, 0, 1'b1);
    wait_drain(60, "post_rst_drain");

    chk("overflow_pulses", 64'(ovf_cnt), 64'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
